// File: rtl/uart_activity_leds.sv
// rtl/uart_activity_leds.sv - multi-channel line activity detector with stretched, optionally blinking LED outputs
// Each channel: 2-flop synchroniser plus history flop, idle-departure edge, tick-decremented stretch timer.
module uart_activity_leds #(
  parameter int CHANNELS       = 2,
  parameter int PRESCALE_WIDTH = 18,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int LED_TIMEOUT    = 25,
  parameter bit IDLE_LEVEL     = 1'b1,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                clk32m,
  input  logic                rst,
  input  logic [CHANNELS-1:0] line_in,
  input  logic [CHANNELS-1:0] blink_en,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] active,
  output logic                tick
);

  localparam logic [CHANNELS-1:0]      IDLE_VEC     = {CHANNELS{IDLE_LEVEL}};
  localparam logic [CHANNELS-1:0]      LED_POL      = {CHANNELS{LED_ACTIVE_LOW}};
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LOAD = TIMEOUT_WIDTH'(LED_TIMEOUT);

  generate
    if (LED_TIMEOUT < 0 || LED_TIMEOUT >= (2 ** TIMEOUT_WIDTH)) begin : g_bad_timeout
      $error("LED_TIMEOUT does not fit in TIMEOUT_WIDTH bits");
    end
  endgenerate

  logic [CHANNELS-1:0]       s1_q, s2_q, s3_q;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      phase_q, phase_d;
  logic [TIMEOUT_WIDTH-1:0]  timer_q [CHANNELS];
  logic [TIMEOUT_WIDTH-1:0]  timer_d [CHANNELS];
  logic [CHANNELS-1:0]       led_q, led_d;
  logic [CHANNELS-1:0]       act_edge;
  logic [CHANNELS-1:0]       lit;

  // Only a departure from idle counts; returning to idle or staying away never retriggers.
  assign act_edge = ~(s3_q ^ IDLE_VEC) & (s2_q ^ IDLE_VEC);

  always_comb begin
    pre_d   = pre_q + 1'b1;
    tick    = &pre_q;
    phase_d = phase_q ^ tick;
    active  = '0;
    lit     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      timer_d[i] = timer_q[i];
      active[i]  = |timer_q[i];
      lit[i]     = active[i] & (~blink_en[i] | phase_q);
      // Load beats decrement when an edge and a tick coincide.
      if (act_edge[i]) begin
        timer_d[i] = TIMEOUT_LOAD;
      end else if (tick && active[i]) begin
        timer_d[i] = timer_q[i] - 1'b1;
      end
    end
    led_d = lit ^ LED_POL;
  end

  always_ff @(posedge clk32m) begin
    if (rst) begin
      s1_q    <= IDLE_VEC;
      s2_q    <= IDLE_VEC;
      s3_q    <= IDLE_VEC;
      pre_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= LED_POL;
      for (int i = 0; i < CHANNELS; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      s1_q    <= line_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_uart_activity_leds.sv
// tb/tb_uart_activity_leds.sv - scoreboard bench: stimulus queues cycle-stamped expectations, monitor checks them
// Observed word per cycle is {tick, active[1:0], led[1:0]}; cyc counts clk32m rising edges.
module tb_uart_activity_leds;

  logic       clk32m = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] line_in  = 2'b11;
  logic [1:0] blink_en = 2'b00;
  logic [1:0] led;
  logic [1:0] active;
  logic       tick;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cyc;
    logic [4:0] exp;
    logic [4:0] mask;
    string      name;
  } chk_t;

  chk_t q[$];

  localparam logic [4:0] M_ALL  = 5'b11111;
  localparam logic [4:0] M_TICK = 5'b10000;
  localparam logic [4:0] M_ACT  = 5'b01100;
  localparam logic [4:0] M_LED  = 5'b00011;
  localparam logic [4:0] M_AL   = 5'b01111;

  uart_activity_leds #(
    .CHANNELS      (2),
    .PRESCALE_WIDTH(4),
    .TIMEOUT_WIDTH (8),
    .LED_TIMEOUT   (3),
    .IDLE_LEVEL    (1'b1),
    .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk32m  (clk32m),
    .rst     (rst),
    .line_in (line_in),
    .blink_en(blink_en),
    .led     (led),
    .active  (active),
    .tick    (tick)
  );

  always #5 clk32m = ~clk32m;

  always @(posedge clk32m) cyc <= cyc + 1;

  task automatic add(input int c, input logic [4:0] e, input logic [4:0] m, input string n);
    chk_t k;
    k.cyc  = c;
    k.exp  = e;
    k.mask = m;
    k.name = n;
    q.push_back(k);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk32m);
  endtask

  // Monitor: every falling edge, retire all expectations stamped for this cycle.
  always @(negedge clk32m) begin
    logic [4:0] obs;
    obs = {tick, active, led};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: missed check for cyc %0d (now %0d)", q[i].name, q[i].cyc, cyc);
        q.delete(i);
      end else if (q[i].cyc == cyc) begin
        n_tests++;
        if ((obs & q[i].mask) !== (q[i].exp & q[i].mask)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %b need %b (mask %b, bits tick/act1/act0/led1/led0)",
                   q[i].name, cyc, obs & q[i].mask, q[i].exp & q[i].mask, q[i].mask);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for edges 1..5; tick period 16, first tick 15 cycles after release -> cyc 20, 36, 52 ...
    add(3,  5'b0_00_11, M_ALL,  "in_reset");
    add(6,  5'b0_00_11, M_ALL,  "after_release");
    add(19, 5'b0_00_00, M_TICK, "tick_before_first");
    add(20, 5'b1_00_00, M_TICK, "tick_first");
    add(21, 5'b0_00_00, M_TICK, "tick_one_wide");
    add(35, 5'b0_00_00, M_TICK, "tick_gap");
    add(36, 5'b1_00_00, M_TICK, "tick_second");
    add(52, 5'b1_00_00, M_TICK, "tick_third");
    wait_cyc(5);
    rst = 1'b0;

    // Pulse ch0 low for 2 cycles: sampled at edge 23, load at 25, led at 26; ticks 36/52/68 -> off at 69.
    wait_cyc(22);
    add(24, 5'b0_00_11, M_AL,  "t2_before_load");
    add(25, 5'b0_01_11, M_AL,  "t2_active_rise");
    add(26, 5'b0_01_10, M_AL,  "t2_led_on");
    add(68, 5'b1_01_10, M_ALL, "t2_last_tick");
    add(69, 5'b0_00_10, M_AL,  "t2_active_fall");
    add(70, 5'b0_00_11, M_AL,  "t2_led_off");
    line_in[0] = 1'b0;
    wait_cyc(24);
    line_in[0] = 1'b1;

    // Load at edge 85 coincides with tick in cycle 84: timer stays 3, off after ticks 100/116/132.
    wait_cyc(82);
    add(84,  5'b1_00_11, M_ALL, "t3_tick_at_load");
    add(85,  5'b0_01_11, M_AL,  "t3_loaded");
    add(86,  5'b0_01_10, M_AL,  "t3_led_on");
    add(116, 5'b1_01_10, M_ALL, "t3_second_tick");
    add(117, 5'b0_01_10, M_AL,  "t3_still_active");
    add(132, 5'b1_01_10, M_ALL, "t3_third_tick");
    add(133, 5'b0_00_10, M_AL,  "t3_active_fall");
    add(134, 5'b0_00_11, M_AL,  "t3_led_off");
    line_in[0] = 1'b0;
    wait_cyc(84);
    line_in[0] = 1'b1;

    // Retrigger every 20 cycles: loads at 143..323; last decrements at 325/341/357.
    wait_cyc(140);
    add(142, 5'b0_00_00, M_ACT, "t4_idle_before");
    for (int c = 143; c <= 356; c++) add(c, 5'b0_01_00, M_ACT, "t4_active_hold");
    for (int c = 144; c <= 357; c++) add(c, 5'b0_00_10, M_LED, "t4_led_hold");
    add(357, 5'b0_00_00, M_ACT, "t4_active_fall");
    add(358, 5'b0_00_11, M_LED, "t4_led_off");
    for (int i = 0; i < 10; i++) begin
      wait_cyc(140 + 20 * i);
      line_in[0] = 1'b0;
      wait_cyc(142 + 20 * i);
      line_in[0] = 1'b1;
    end

    // Blink on ch1: load 365, phase 0 until 373, 1 until 389, then 0; override blink 392..396.
    wait_cyc(360);
    blink_en = 2'b10;
    add(364, 5'b0_00_11, M_AL,  "t5_before_load");
    add(365, 5'b0_10_11, M_AL,  "t5_loaded_phase0");
    add(373, 5'b0_10_11, M_AL,  "t5_led_dark_phase0");
    add(374, 5'b0_10_01, M_AL,  "t5_led_lit_phase1");
    add(389, 5'b0_10_01, M_AL,  "t5_led_lit_end");
    add(390, 5'b0_10_11, M_AL,  "t5_led_dark_phase0b");
    add(392, 5'b0_10_11, M_AL,  "t5_before_override");
    add(393, 5'b0_10_01, M_AL,  "t5_solid_override");
    add(396, 5'b0_10_01, M_AL,  "t5_solid_hold");
    add(397, 5'b0_10_11, M_AL,  "t5_blink_restored");
    add(404, 5'b1_10_11, M_ALL, "t5_last_tick");
    add(405, 5'b0_00_11, M_AL,  "t5_active_fall");
    add(406, 5'b0_00_11, M_AL,  "t5_led_off");
    wait_cyc(362);
    line_in[1] = 1'b0;
    wait_cyc(364);
    line_in[1] = 1'b1;
    wait_cyc(392);
    blink_en = 2'b00;
    wait_cyc(396);
    blink_en = 2'b10;

    // Reset mid-pulse with ch0 held low across release; prescaler restarts (tick 15 cycles later).
    wait_cyc(410);
    blink_en = 2'b00;
    add(413, 5'b0_01_11, M_AL,   "t6_loaded");
    add(414, 5'b0_01_10, M_AL,   "t6_led_on");
    add(420, 5'b0_01_10, M_AL,   "t6_before_reset");
    add(421, 5'b0_00_11, M_ALL,  "t6_reset_kills");
    add(422, 5'b0_00_11, M_ALL,  "t6_reset_held");
    add(423, 5'b0_00_11, M_ALL,  "t6_post_release1");
    add(424, 5'b0_00_11, M_ALL,  "t6_post_release2");
    add(436, 5'b0_00_00, M_TICK, "t6_tick_gap");
    add(437, 5'b1_00_00, M_TICK, "t6_tick_restart");
    add(438, 5'b0_00_00, M_TICK, "t6_tick_one_wide");
    line_in[0] = 1'b0;
    wait_cyc(420);
    rst = 1'b1;
    wait_cyc(422);
    rst = 1'b0;
    wait_cyc(424);
    line_in[0] = 1'b1;

    while (q.size() > 0 && cyc < 700) @(negedge clk32m);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks never reached, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
